coax_rx_sequencer: RTL and testbench
====================================

COAX_RX_SEQUENCER -- requirements
Module: coax_rx_sequencer

Interface
REQ-001 Parameter QUIESCE_BITS, default 5: minimum consecutive 1 samples that arm frame start.
REQ-002 Parameter MAX_WORDS, default 32: maximum words per frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  receiver enable; low forces DISABLED.
REQ-006 bit_sample  input  1  one-cycle strobe from bit timer: bit_value valid.
REQ-007 bit_value  input  1  sampled bit, valid only with bit_sample.
REQ-008 bit_synchronized  input  1  bit timer lock indicator.
REQ-009 timer_reset  output  1  active-high reset to bit timer.
REQ-010 active  output  1  high while in SYNC, DATA or PARITY.
REQ-011 data  output  10  received word, held while data_valid.
REQ-012 data_parity_error  output  1  parity flag for data, held while data_valid.
REQ-013 data_valid  output  1  word available.
REQ-014 data_ready  input  1  consumer accepts word when high with data_valid.
REQ-015 frame_end  output  1  one-cycle pulse at frame end.
REQ-016 error  output  1  sticky error flag.
REQ-017 error_code  output  2  0 none, 1 loss of sync, 2 overrun, 3 word overflow.
REQ-018 error_clear  input  1  one-cycle request to leave ERROR.

Function
REQ-019 States: DISABLED, HUNT, SYNC, DATA, PARITY, ERROR; bits processed only in cycles with bit_sample high.
REQ-020 DISABLED: timer_reset=1; enable high -> HUNT next cycle with ones counter cleared.
REQ-021 HUNT: timer_reset=0; sample 1 increments ones counter, saturating at QUIESCE_BITS; sample 0 with counter==QUIESCE_BITS -> SYNC, word count cleared; sample 0 otherwise clears counter.
REQ-022 SYNC: sample 1 -> DATA with bit counter 0; sample 0 -> frame end: frame_end pulses next cycle, timer_reset pulses one cycle, state -> HUNT with counter cleared.
REQ-023 DATA: 10 samples shifted in MSB first; after the 10th -> PARITY.
REQ-024 PARITY: parity sample; data_parity_error = XOR of 10 data bits XOR parity bit (even parity over 11 bits); -> SYNC.
REQ-025 Word delivery: data, data_parity_error, data_valid=1 registered the cycle after parity sample; parity error never aborts frame.
REQ-026 data_valid clears the cycle after a cycle with data_valid and data_ready both high; data and data_parity_error stable until then.
REQ-027 Overrun: word completes while data_valid high and data_ready low that same cycle -> ERROR code 2; buffered word retained, new word dropped.
REQ-028 Completing word with data_ready high that cycle: new word replaces old, data_valid stays 1, no error.
REQ-029 Word count increments per delivered word; parity sample that would make count exceed MAX_WORDS -> ERROR code 3, word dropped.
REQ-030 bit_synchronized low in any active state -> ERROR code 1 next cycle; ignored in HUNT.
REQ-031 ERROR: error=1, error_code held, timer_reset=1, samples ignored; error_clear -> HUNT, error and error_code cleared next cycle.
REQ-032 Simultaneous error_clear and bit_sample: clear wins, sample discarded.
REQ-033 Multiple error conditions in one cycle: priority code 1 > 2 > 3.
REQ-034 enable low in any state -> DISABLED next cycle, no error, no frame_end; error, error_code, data_valid cleared.
REQ-035 Enable low takes priority over every other event.

Reset
REQ-036 reset_n low asynchronously forces: state DISABLED, timer_reset=1, active=0, data=0, data_parity_error=0, data_valid=0, frame_end=0, error=0, error_code=0, counters 0.
REQ-037 Reset asserted mid-frame discards partial word without frame_end or error.
REQ-038 After reset_n rises, first state change occurs on a following clk edge.

Verification
REQ-039 enable=1, 5 ones, 0, sync 1, data 10'b1010011010, parity 1, sync 0 -> data_valid with data=0x29A, data_parity_error=0, then frame_end pulse, timer_reset pulse, HUNT.
REQ-040 Same frame, parity bit 0 -> data=0x29A, data_parity_error=1, frame continues, no error.
REQ-041 Two-word frame, data_ready=0 throughout -> first word held, ERROR code 2 after second parity sample; error_clear -> HUNT, error=0.
REQ-042 4 ones then 0 -> stays HUNT; then 5 ones, 0 -> SYNC (active=1).
REQ-043 bit_synchronized low during DATA -> ERROR code 1, timer_reset=1; MAX_WORDS=2, three-word frame -> ERROR code 3 at third parity.
REQ-044 reset_n low mid-DATA and enable low mid-frame -> DISABLED, all outputs at reset values, no frame_end.

Source files
------------

// File: rtl/coax_rx_sequencer.sv
// Coax receive sequencer: hunts for a quiet-line preamble, then frames sync/data/parity
// bit groups into 10-bit words with a one-deep output buffer and sticky error reporting.
module coax_rx_sequencer #(
  parameter int unsigned QUIESCE_BITS = 5,
  parameter int unsigned MAX_WORDS    = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       bit_sample,
  input  logic       bit_value,
  input  logic       bit_synchronized,
  output logic       timer_reset,
  output logic       active,
  output logic [9:0] data,
  output logic       data_parity_error,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_end,
  output logic       error,
  output logic [1:0] error_code,
  input  logic       error_clear
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned ONES_W = $clog2(QUIESCE_BITS + 1);
  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned BCNT_W = 4;

  localparam logic [1:0] ERR_SYNC     = 2'd1;
  localparam logic [1:0] ERR_OVERRUN  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_DISABLED,
    S_HUNT,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [1:0]          code_q, code_d;
  logic                frame_end_q, frame_end_d;
  logic                timer_reset_q, timer_reset_d;
  logic                active_q, active_d;
  logic                word_parity;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_DISABLED;
      ones_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      word_cnt_q    <= '0;
      data_q        <= '0;
      perr_q        <= 1'b0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      code_q        <= '0;
      frame_end_q   <= 1'b0;
      timer_reset_q <= 1'b1;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      word_cnt_q    <= word_cnt_d;
      data_q        <= data_d;
      perr_q        <= perr_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
      code_q        <= code_d;
      frame_end_q   <= frame_end_d;
      timer_reset_q <= timer_reset_d;
      active_q      <= active_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_cnt_d  = word_cnt_q;
    data_d      = data_q;
    perr_d      = perr_q;
    valid_d     = valid_q;
    error_d     = error_q;
    code_d      = code_q;
    frame_end_d = 1'b0;
    word_parity = (^shift_q) ^ bit_value;

    // Consumer handshake; a word delivered this cycle overrides the clear below
    if (valid_q && data_ready) valid_d = 1'b0;

    case (state_q)
      S_DISABLED: begin
        if (enable) begin
          state_d = S_HUNT;
          ones_d  = '0;
        end
      end
      S_HUNT: begin
        if (bit_sample) begin
          if (bit_value) begin
            if (ones_q != ONES_W'(QUIESCE_BITS)) ones_d = ones_q + ONES_W'(1);
          end else if (ones_q == ONES_W'(QUIESCE_BITS)) begin
            state_d    = S_SYNC;
            word_cnt_d = '0;
          end else begin
            ones_d = '0;
          end
        end
      end
      S_SYNC, S_DATA, S_PARITY: begin
        if (!bit_synchronized) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          code_d  = ERR_SYNC;
        end else if (bit_sample) begin
          if (state_q == S_SYNC) begin
            if (bit_value) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d     = S_HUNT;
              ones_d      = '0;
              frame_end_d = 1'b1;
            end
          end else if (state_q == S_DATA) begin
            shift_d   = {shift_q[WORD_W-2:0], bit_value};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(WORD_W - 1)) state_d = S_PARITY;
          end else begin
            // Overrun outranks overflow when both apply
            if (valid_q && !data_ready) begin
              state_d = S_ERROR;
              error_d = 1'b1;
              code_d  = ERR_OVERRUN;
            end else if (word_cnt_q == WCNT_W'(MAX_WORDS)) begin
              state_d = S_ERROR;
              error_d = 1'b1;
              code_d  = ERR_OVERFLOW;
            end else begin
              state_d    = S_SYNC;
              data_d     = shift_q;
              perr_d     = word_parity;
              valid_d    = 1'b1;
              word_cnt_d = word_cnt_q + WCNT_W'(1);
            end
          end
        end
      end
      S_ERROR: begin
        if (error_clear) begin
          state_d = S_HUNT;
          ones_d  = '0;
          error_d = 1'b0;
          code_d  = '0;
        end
      end
      default: state_d = S_DISABLED;
    endcase

    // Disable overrides everything and returns the block to its reset image
    if (!enable) begin
      state_d     = S_DISABLED;
      ones_d      = '0;
      bit_cnt_d   = '0;
      shift_d     = '0;
      word_cnt_d  = '0;
      data_d      = '0;
      perr_d      = 1'b0;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      code_d      = '0;
      frame_end_d = 1'b0;
    end

    timer_reset_d = (state_d == S_DISABLED) || (state_d == S_ERROR) || frame_end_d;
    active_d      = (state_d == S_SYNC) || (state_d == S_DATA) || (state_d == S_PARITY);
  end

  assign timer_reset       = timer_reset_q;
  assign active            = active_q;
  assign data              = data_q;
  assign data_parity_error = perr_q;
  assign data_valid        = valid_q;
  assign frame_end         = frame_end_q;
  assign error             = error_q;
  assign error_code        = code_q;

endmodule

// File: tb/tb_coax_rx_sequencer.sv
// Bench for coax_rx_sequencer: directed scenario tasks plus randomized frames
// checked against a word-level model of what the receiver should deliver.
module tb_coax_rx_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       bit_sample;
  logic       bit_value;
  logic       bit_synchronized;
  logic       timer_reset;
  logic       active;
  logic [9:0] data;
  logic       data_parity_error;
  logic       data_valid;
  logic       data_ready;
  logic       frame_end;
  logic       error;
  logic [1:0] error_code;
  logic       error_clear;

  int total = 0;
  int bad   = 0;

  bit          rnd_rdy = 1'b0;
  bit          rnd_gap = 1'b0;
  bit          mon_en  = 1'b0;
  int          fe_cnt  = 0;
  logic [10:0] got_q[$];

  localparam logic [17:0] RST_OUTS = {1'b1, 17'd0};

  coax_rx_sequencer #(.QUIESCE_BITS(5), .MAX_WORDS(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bit_sample(bit_sample),
    .bit_value(bit_value), .bit_synchronized(bit_synchronized), .timer_reset(timer_reset),
    .active(active), .data(data), .data_parity_error(data_parity_error),
    .data_valid(data_valid), .data_ready(data_ready), .frame_end(frame_end),
    .error(error), .error_code(error_code), .error_clear(error_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records accepted words and frame_end pulses away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid && data_ready) got_q.push_back({data_parity_error, data});
      if (frame_end) fe_cnt++;
    end
  end

  function automatic logic [17:0] outs();
    return {timer_reset, active, data_valid, frame_end, error, error_code, data_parity_error, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input bit force_rdy);
    int g;
    bit_value  = v;
    bit_sample = 1'b1;
    if (force_rdy) data_ready = 1'b1;
    tick();
    bit_sample = 1'b0;
    bit_value  = 1'b0;
    if (rnd_rdy) data_ready = 1'($urandom_range(0, 1));
    g = rnd_gap ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      tick();
      if (rnd_rdy) data_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_preamble(input int n);
    repeat (n) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [9:0] w, input logic p, input bit force_rdy);
    send_bit(1'b1, 1'b0);
    for (int i = 9; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit(p, force_rdy);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", outs(), RST_OUTS);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL disabled_hold got=%h exp=%h", outs(), RST_OUTS);
    end
  endtask

  task automatic test_basic_frame();
    logic [9:0] w;
    w = 10'h29A;
    enable = 1'b1;
    data_ready = 1'b0;
    tick();
    total++;
    if (timer_reset !== 1'b0) begin
      bad++;
      $display("FAIL hunt_timer_reset got=%b exp=0", timer_reset);
    end
    send_preamble(5);
    total++;
    if (active !== 1'b1) begin
      bad++;
      $display("FAIL sync_active got=%b exp=1", active);
    end
    send_word(w, 1'b1, 1'b0);
    total++;
    if ({data_valid, data_parity_error, data} !== {1'b1, (^w) ^ 1'b1, w}) begin
      bad++;
      $display("FAIL word_basic got=%b/%b/%h exp=1/0/29a", data_valid, data_parity_error, data);
    end
    send_bit(1'b0, 1'b0);
    total++;
    if ({frame_end, timer_reset, active} !== 3'b110) begin
      bad++;
      $display("FAIL frame_end_pulse got=%b exp=110", {frame_end, timer_reset, active});
    end
    tick();
    total++;
    if ({frame_end, timer_reset, data_valid} !== 3'b001) begin
      bad++;
      $display("FAIL after_frame got=%b exp=001", {frame_end, timer_reset, data_valid});
    end
    data_ready = 1'b1;
    tick();
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("FAIL handshake_clear got=%b exp=0", data_valid);
    end
  endtask

  task automatic test_parity_error();
    logic [9:0] w;
    data_ready = 1'b1;
    send_preamble(5);
    w = 10'h29A;
    send_word(w, 1'b0, 1'b0);
    total++;
    if ({data_valid, data_parity_error, data, error} !== {1'b1, (^w) ^ 1'b0, w, 1'b0}) begin
      bad++;
      $display("FAIL parity_err_word got=%b/%b/%h/%b exp=1/1/%h/0", data_valid, data_parity_error, data, error, w);
    end
    w = 10'h155;
    send_word(w, 1'b0, 1'b0);
    total++;
    if ({data_valid, data_parity_error, data, active} !== {1'b1, (^w) ^ 1'b0, w, 1'b1}) begin
      bad++;
      $display("FAIL parity_err_continue got=%b/%b/%h/%b exp=1/1/%h/1", data_valid, data_parity_error, data, active, w);
    end
    send_bit(1'b0, 1'b0);
    total++;
    if ({frame_end, error} !== 2'b10) begin
      bad++;
      $display("FAIL parity_err_frame_end got=%b exp=10", {frame_end, error});
    end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    send_preamble(5);
    send_word(10'h0F0, 1'b0, 1'b0);
    send_word(10'h3C1, 1'b1, 1'b0);
    total++;
    if ({error, error_code, data_valid, data, timer_reset, active} !== {1'b1, 2'd2, 1'b1, 10'h0F0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL overrun got=%b/%0d/%b/%h/%b/%b exp=1/2/1/0f0/1/0",
               error, error_code, data_valid, data, timer_reset, active);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    total++;
    if ({error, error_code} !== {1'b1, 2'd2}) begin
      bad++;
      $display("FAIL error_sticky got=%b/%0d exp=1/2", error, error_code);
    end
    error_clear = 1'b1;
    bit_sample  = 1'b1;
    bit_value   = 1'b0;
    tick();
    error_clear = 1'b0;
    bit_sample  = 1'b0;
    total++;
    if ({error, error_code, timer_reset, active, data_valid} !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL error_clear got=%b/%0d/%b/%b/%b exp=0/0/0/0/1", error, error_code, timer_reset, active, data_valid);
    end
    data_ready = 1'b1;
    tick();
  endtask

  task automatic test_hunt();
    data_ready = 1'b1;
    send_preamble(4);
    total++;
    if (active !== 1'b0) begin
      bad++;
      $display("FAIL short_preamble got=%b exp=0", active);
    end
    send_preamble(5);
    total++;
    if (active !== 1'b1) begin
      bad++;
      $display("FAIL full_preamble got=%b exp=1", active);
    end
    send_bit(1'b0, 1'b0);
    send_preamble(8);
    total++;
    if (active !== 1'b1) begin
      bad++;
      $display("FAIL saturated_preamble got=%b exp=1", active);
    end
    send_bit(1'b0, 1'b0);
  endtask

  task automatic test_sync_loss();
    send_preamble(5);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    bit_synchronized = 1'b0;
    tick();
    bit_synchronized = 1'b1;
    total++;
    if ({error, error_code, timer_reset, active} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sync_loss got=%b/%0d/%b/%b exp=1/1/1/0", error, error_code, timer_reset, active);
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    // Sync loss coinciding with an overrun parity sample
    data_ready = 1'b0;
    send_preamble(5);
    send_word(10'h001, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    bit_value        = 1'b0;
    bit_sample       = 1'b1;
    bit_synchronized = 1'b0;
    tick();
    bit_sample       = 1'b0;
    bit_synchronized = 1'b1;
    total++;
    if ({error, error_code, data} !== {1'b1, 2'd1, 10'h001}) begin
      bad++;
      $display("FAIL sync_over_overrun got=%b/%0d/%h exp=1/1/001", error, error_code, data);
    end
    error_clear = 1'b1;
    data_ready  = 1'b1;
    tick();
    error_clear = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [9:0] w;
    data_ready = 1'b1;
    send_preamble(5);
    for (int i = 0; i < 2; i++) begin
      w = 10'($urandom);
      send_word(w, 1'($urandom_range(0, 1)), 1'b0);
    end
    total++;
    if ({error, data_valid} !== 2'b01) begin
      bad++;
      $display("FAIL two_words_ok got=%b/%b exp=0/1", error, data_valid);
    end
    send_word(10'($urandom), 1'b0, 1'b0);
    total++;
    if ({error, error_code, data_valid} !== {1'b1, 2'd3, 1'b0}) begin
      bad++;
      $display("FAIL word_overflow got=%b/%0d/%b exp=1/3/0", error, error_code, data_valid);
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  task automatic test_enable_low();
    data_ready = 1'b0;
    send_preamble(5);
    send_word(10'($urandom), 1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    enable = 1'b0;
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL enable_low_mid_frame got=%h exp=%h", outs(), RST_OUTS);
    end
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL stay_disabled got=%h exp=%h", outs(), RST_OUTS);
    end
    enable = 1'b1;
    tick();
    send_preamble(5);
    send_bit(1'b1, 1'b0);
    bit_synchronized = 1'b0;
    tick();
    bit_synchronized = 1'b1;
    enable = 1'b0;
    tick();
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL enable_low_clears_error got=%h exp=%h", outs(), RST_OUTS);
    end
    enable = 1'b1;
    tick();
    send_preamble(5);
    send_word(10'($urandom), 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL async_reset_mid_data got=%h exp=%h", outs(), RST_OUTS);
    end
    tick();
    reset_n = 1'b1;
    data_ready = 1'b1;
    tick();
    total++;
    if ({timer_reset, active, frame_end} !== 3'b000) begin
      bad++;
      $display("FAIL hunt_after_reset got=%b exp=000", {timer_reset, active, frame_end});
    end
  endtask

  task automatic test_random_frames();
    logic [10:0] exp_q[$];
    logic [9:0]  w;
    logic        p;
    int          frames;
    frames  = 20;
    got_q.delete();
    fe_cnt  = 0;
    mon_en  = 1'b1;
    rnd_rdy = 1'b1;
    rnd_gap = 1'b1;
    for (int f = 0; f < frames; f++) begin
      send_preamble(int'($urandom_range(5, 8)));
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        w = 10'($urandom);
        p = 1'($urandom_range(0, 1));
        exp_q.push_back({(^w) ^ p, w});
        send_word(w, p, 1'b1);
      end
      send_bit(1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_rdy    = 1'b0;
    rnd_gap    = 1'b0;
    data_ready = 1'b1;
    repeat (3) tick();
    mon_en = 1'b0;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL rand_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (fe_cnt !== frames) begin
      bad++;
      $display("FAIL rand_frame_end got=%0d exp=%0d", fe_cnt, frames);
    end
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL rand_no_error got=%b exp=0", error);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    bit_sample       = 1'b0;
    bit_value        = 1'b0;
    bit_synchronized = 1'b1;
    data_ready       = 1'b0;
    error_clear      = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity_error();
    test_overrun();
    test_hunt();
    test_sync_loss();
    test_overflow();
    test_enable_low();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
